// File: rtl/mat_input_loader_pkg.sv
// Shared constants, state encoding and row types for the matmul input loader.
package mat_input_loader_pkg;
  localparam int DEF_DWIDTH       = 8;
  localparam int DEF_MAT_MUL_SIZE = 8;
  localparam int DEF_AWIDTH       = 10;
  localparam int DEF_STRIDE_W     = 8;
  localparam int ROW_BITS         = DEF_DWIDTH * DEF_MAT_MUL_SIZE;
  // Wide enough to hold a row count of 0..MAT_MUL_SIZE inclusive.
  localparam int ROW_CNT_W        = $clog2(DEF_MAT_MUL_SIZE + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_START,
    ST_WAIT,
    ST_CLEAR,
    ST_DONE
  } state_e;

  typedef logic [ROW_CNT_W-1:0] row_cnt_t;
endpackage

// File: rtl/mat_input_loader_if.sv
// Valid/ready row stream feeding the loader; one beat is one matrix row.
interface mat_input_loader_if #(
  parameter int DW = 64
);
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/mat_input_loader_row_writer.sv
// One RAM write port: latches base/stride/mask at start and turns each
// accepted beat into a registered write at a running address.
module mat_row_writer
  import mat_input_loader_pkg::*;
#(
  parameter int AW = DEF_AWIDTH,
  parameter int SW = DEF_STRIDE_W,
  parameter int RW = ROW_BITS,
  parameter int NB = DEF_MAT_MUL_SIZE
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          init,
  input  logic [AW-1:0] cfg_base,
  input  logic [SW-1:0] cfg_stride,
  input  logic [NB-1:0] cfg_mask,
  input  logic          beat,
  input  logic [RW-1:0] data,
  output logic [AW-1:0] bram_addr,
  output logic [RW-1:0] bram_wdata,
  output logic [NB-1:0] bram_we
);
  logic [AW-1:0] addr_acc;
  logic [SW-1:0] stride_q;
  logic [NB-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_acc   <= '0;
      stride_q   <= '0;
      mask_q     <= '0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      bram_we    <= '0;
    end else begin
      bram_we <= '0;
      if (init) begin
        addr_acc <= cfg_base;
        stride_q <= cfg_stride;
        mask_q   <= cfg_mask;
      end else if (beat) begin
        bram_addr  <= addr_acc;
        bram_wdata <= data;
        bram_we    <= mask_q;
        // Address wraps modulo 2^AW by plain truncation.
        addr_acc   <= addr_acc + AW'(stride_q);
      end
    end
  end
endmodule

// File: rtl/mat_input_loader.sv
// Loads matrix A then B from a row stream into the matmul RAMs, then runs
// the start / wait-done / clear-done handshake with the multiplier.
module mat_input_loader
  import mat_input_loader_pkg::*;
#(
  parameter int DWIDTH            = DEF_DWIDTH,
  parameter int MAT_MUL_SIZE      = DEF_MAT_MUL_SIZE,
  parameter int AWIDTH            = DEF_AWIDTH,
  parameter int ADDR_STRIDE_WIDTH = DEF_STRIDE_W
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cfg_start,
  input  logic                          cfg_clear,
  input  logic [AWIDTH-1:0]             cfg_addr_a,
  input  logic [AWIDTH-1:0]             cfg_addr_b,
  input  logic [ADDR_STRIDE_WIDTH-1:0]  cfg_stride_a,
  input  logic [ADDR_STRIDE_WIDTH-1:0]  cfg_stride_b,
  input  row_cnt_t                      cfg_rows_a,
  input  row_cnt_t                      cfg_rows_b,
  input  logic [MAT_MUL_SIZE-1:0]       cfg_mask_a,
  input  logic [MAT_MUL_SIZE-1:0]       cfg_mask_b,
  mat_input_loader_if.slave             s,
  output logic [AWIDTH-1:0]             bram_addr_a,
  output logic [DWIDTH*MAT_MUL_SIZE-1:0] bram_wdata_a,
  output logic [MAT_MUL_SIZE-1:0]       bram_we_a,
  output logic [AWIDTH-1:0]             bram_addr_b,
  output logic [DWIDTH*MAT_MUL_SIZE-1:0] bram_wdata_b,
  output logic [MAT_MUL_SIZE-1:0]       bram_we_b,
  output logic                          mm_start_reg,
  output logic                          mm_clear_done_reg,
  input  logic                          mm_done,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);
  localparam int RW = DWIDTH * MAT_MUL_SIZE;

  state_e   state, next;
  row_cnt_t rows_a_q, rows_b_q, row_cnt, rows_cur;
  logic     accept, in_a, in_b, start_ok, final_row, last_beat, frame_err;

  assign accept    = s.s_valid && s.s_ready;
  assign in_a      = (state == ST_LOAD_A);
  assign in_b      = (state == ST_LOAD_B);
  assign start_ok  = (state == ST_IDLE) && cfg_start;
  assign rows_cur  = in_b ? rows_b_q : rows_a_q;
  assign final_row = (row_cnt == rows_cur - ROW_CNT_W'(1));
  assign last_beat = accept && (s.s_last || final_row);
  // Early s_last truncates the matrix; a missing s_last on the final row only flags.
  assign frame_err = accept && (s.s_last != final_row);

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE: if (cfg_start) begin
        if (cfg_rows_a != '0)      next = ST_LOAD_A;
        else if (cfg_rows_b != '0) next = ST_LOAD_B;
        else                       next = ST_START;
      end
      ST_LOAD_A: if (last_beat) next = (rows_b_q != '0) ? ST_LOAD_B : ST_START;
      ST_LOAD_B: if (last_beat) next = ST_START;
      ST_START:  next = ST_WAIT;
      ST_WAIT:   if (mm_done) next = ST_CLEAR;
      ST_CLEAR:  next = ST_DONE;
      ST_DONE:   if (cfg_clear) next = ST_IDLE;
      default:   next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s.s_ready         <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      mm_start_reg      <= 1'b0;
      mm_clear_done_reg <= 1'b0;
      rows_a_q          <= '0;
      rows_b_q          <= '0;
      row_cnt           <= '0;
    end else begin
      s.s_ready         <= (next == ST_LOAD_A) || (next == ST_LOAD_B);
      busy              <= (next != ST_IDLE) && (next != ST_DONE);
      done              <= (next == ST_DONE);
      // Pulses trail their state by one cycle so the last RAM write lands first.
      mm_start_reg      <= (state == ST_START);
      mm_clear_done_reg <= (state == ST_CLEAR);
      if (start_ok) begin
        rows_a_q <= cfg_rows_a;
        rows_b_q <= cfg_rows_b;
      end
      if (start_ok)       err <= 1'b0;
      else if (frame_err) err <= 1'b1;
      if (state == ST_IDLE) row_cnt <= '0;
      else if (accept)      row_cnt <= last_beat ? '0 : row_cnt + ROW_CNT_W'(1);
    end
  end

  mat_row_writer #(.AW(AWIDTH), .SW(ADDR_STRIDE_WIDTH), .RW(RW), .NB(MAT_MUL_SIZE)) u_wr_a (
    .clk        (clk),
    .resetn     (resetn),
    .init       (start_ok),
    .cfg_base   (cfg_addr_a),
    .cfg_stride (cfg_stride_a),
    .cfg_mask   (cfg_mask_a),
    .beat       (accept && in_a),
    .data       (s.s_data),
    .bram_addr  (bram_addr_a),
    .bram_wdata (bram_wdata_a),
    .bram_we    (bram_we_a)
  );

  mat_row_writer #(.AW(AWIDTH), .SW(ADDR_STRIDE_WIDTH), .RW(RW), .NB(MAT_MUL_SIZE)) u_wr_b (
    .clk        (clk),
    .resetn     (resetn),
    .init       (start_ok),
    .cfg_base   (cfg_addr_b),
    .cfg_stride (cfg_stride_b),
    .cfg_mask   (cfg_mask_b),
    .beat       (accept && in_b),
    .data       (s.s_data),
    .bram_addr  (bram_addr_b),
    .bram_wdata (bram_wdata_b),
    .bram_we    (bram_we_b)
  );
endmodule

// File: tb/tb_mat_input_loader.sv
// Scoreboarded bench for mat_input_loader: expected RAM writes are queued as
// beats are accepted and retired against the write ports each cycle.
module tb_mat_input_loader;
  import mat_input_loader_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_start = 1'b0, cfg_clear = 1'b0;
  logic [9:0]  cfg_addr_a = '0, cfg_addr_b = '0;
  logic [7:0]  cfg_stride_a = '0, cfg_stride_b = '0;
  row_cnt_t    cfg_rows_a = '0, cfg_rows_b = '0;
  logic [7:0]  cfg_mask_a = '0, cfg_mask_b = '0;
  logic [9:0]  bram_addr_a, bram_addr_b;
  logic [63:0] bram_wdata_a, bram_wdata_b;
  logic [7:0]  bram_we_a, bram_we_b;
  logic        mm_start_reg, mm_clear_done_reg, busy, done, err;
  logic        mm_done = 1'b0;

  always #5 clk = ~clk;

  mat_input_loader_if #(.DW(64)) sif ();

  mat_input_loader dut (
    .clk (clk), .resetn (resetn), .cfg_start (cfg_start), .cfg_clear (cfg_clear),
    .cfg_addr_a (cfg_addr_a), .cfg_addr_b (cfg_addr_b),
    .cfg_stride_a (cfg_stride_a), .cfg_stride_b (cfg_stride_b),
    .cfg_rows_a (cfg_rows_a), .cfg_rows_b (cfg_rows_b),
    .cfg_mask_a (cfg_mask_a), .cfg_mask_b (cfg_mask_b),
    .s (sif),
    .bram_addr_a (bram_addr_a), .bram_wdata_a (bram_wdata_a), .bram_we_a (bram_we_a),
    .bram_addr_b (bram_addr_b), .bram_wdata_b (bram_wdata_b), .bram_we_b (bram_we_b),
    .mm_start_reg (mm_start_reg), .mm_clear_done_reg (mm_clear_done_reg), .mm_done (mm_done),
    .busy (busy), .done (done), .err (err)
  );

  typedef struct { logic [9:0] addr; logic [63:0] data; logic [7:0] we; } wr_t;
  wr_t qa[$], qb[$];

  int tests = 0, fails = 0, cyc = 0;
  int start_cnt = 0, clr_cnt = 0, wr_cnt = 0, last_wr_cyc = 0, start_cyc = 0, mm_cnt = 0;

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;
  end

  // Write-port monitor and multiplier model, sampled 2 time units after the edge.
  always @(posedge clk) begin
    wr_t e;
    #2;
    cyc++;
    if (bram_we_a !== 8'h00 || qa.size() != 0) begin
      tests++;
      if (qa.size() == 0) begin
        fails++;
        $display("FAIL wr_a_unexpected: we=%h addr=%h, required no write", bram_we_a, bram_addr_a);
      end else begin
        e = qa.pop_front();
        if (bram_we_a !== e.we || bram_addr_a !== e.addr || bram_wdata_a !== e.data) begin
          fails++;
          $display("FAIL wr_a: got we=%h addr=%h data=%h, required we=%h addr=%h data=%h",
                   bram_we_a, bram_addr_a, bram_wdata_a, e.we, e.addr, e.data);
        end
        wr_cnt++;
        last_wr_cyc = cyc;
      end
    end
    if (bram_we_b !== 8'h00 || qb.size() != 0) begin
      tests++;
      if (qb.size() == 0) begin
        fails++;
        $display("FAIL wr_b_unexpected: we=%h addr=%h, required no write", bram_we_b, bram_addr_b);
      end else begin
        e = qb.pop_front();
        if (bram_we_b !== e.we || bram_addr_b !== e.addr || bram_wdata_b !== e.data) begin
          fails++;
          $display("FAIL wr_b: got we=%h addr=%h data=%h, required we=%h addr=%h data=%h",
                   bram_we_b, bram_addr_b, bram_wdata_b, e.we, e.addr, e.data);
        end
        wr_cnt++;
        last_wr_cyc = cyc;
      end
    end
    if (mm_start_reg === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
      mm_cnt = 40;
    end else if (mm_cnt > 0) begin
      mm_cnt--;
      if (mm_cnt == 0) mm_done = 1'b1;
    end
    if (mm_clear_done_reg === 1'b1) begin
      clr_cnt++;
      mm_done = 1'b0;
    end
  end

  // Presents one row until accepted; the expected write is queued on acceptance.
  task automatic send_row(bit is_b, int r, bit last, bit gaps,
                          logic [9:0] base, logic [7:0] stride, logic [7:0] mask);
    logic [63:0] d;
    wr_t e;
    bit  ok = 1'b0;
    int  t  = 0;
    d = {$urandom, $urandom};
    while (!ok) begin
      @(negedge clk);
      if (gaps && $urandom_range(1) == 0) begin
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
      end else begin
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        sif.s_last  = last;
        if (sif.s_ready === 1'b1) begin
          e.addr = 10'((int'(base) + r * int'(stride)) % 1024);
          e.data = d;
          e.we   = mask;
          if (is_b) qb.push_back(e);
          else      qa.push_back(e);
          ok = 1'b1;
        end
      end
      t++;
      if (!ok && t > 200) begin
        tests++; fails++;
        $display("FAIL ready_timeout: row %0d of %s not accepted, required s_ready", r, is_b ? "B" : "A");
        ok = 1'b1;
      end
    end
  endtask

  task automatic run_op(string nm, logic [9:0] aa, logic [7:0] sa, int ra, logic [7:0] ma,
                        logic [9:0] ab, logic [7:0] sb, int rb, logic [7:0] mb,
                        int last_a, int last_b, bit gaps, bit exp_err);
    int s0 = start_cnt, c0 = clr_cnt, w0 = wr_cnt, na, nb, t;
    na = (last_a >= 0 && last_a < ra) ? last_a + 1 : ra;
    nb = (last_b >= 0 && last_b < rb) ? last_b + 1 : rb;
    @(negedge clk);
    cfg_addr_a = aa; cfg_stride_a = sa; cfg_rows_a = row_cnt_t'(ra); cfg_mask_a = ma;
    cfg_addr_b = ab; cfg_stride_b = sb; cfg_rows_b = row_cnt_t'(rb); cfg_mask_b = mb;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    // Scramble config after the start; the latched copy must be used.
    cfg_addr_a = 10'($urandom); cfg_addr_b = 10'($urandom);
    cfg_stride_a = 8'($urandom); cfg_stride_b = 8'($urandom);
    cfg_mask_a = 8'($urandom); cfg_mask_b = 8'($urandom);
    cfg_rows_a = row_cnt_t'($urandom_range(8)); cfg_rows_b = row_cnt_t'($urandom_range(8));
    tests++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL %s_started: busy=%b err=%b, required busy=1 err=0", nm, busy, err);
    end
    for (int r = 0; r < na; r++) send_row(1'b0, r, r == last_a, gaps, aa, sa, ma);
    for (int r = 0; r < nb; r++) send_row(1'b1, r, r == last_b, gaps, ab, sb, mb);
    @(negedge clk);
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    cfg_start   = 1'b1;
    @(negedge clk);
    cfg_start   = 1'b0;
    t = 0;
    while (done !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s_done_timeout: done=%b, required 1", nm, done);
    end
    tests++;
    if (start_cnt - s0 != 1 || clr_cnt - c0 != 1) begin
      fails++;
      $display("FAIL %s_pulses: start=%0d clear=%0d, required 1 and 1", nm, start_cnt - s0, clr_cnt - c0);
    end
    tests++;
    if (wr_cnt - w0 != na + nb || qa.size() + qb.size() != 0) begin
      fails++;
      $display("FAIL %s_write_count: got %0d pending %0d, required %0d pending 0",
               nm, wr_cnt - w0, qa.size() + qb.size(), na + nb);
    end
    tests++;
    if (err !== exp_err || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_status: err=%b busy=%b, required err=%b busy=0", nm, err, busy, exp_err);
    end
    if (na + nb > 0) begin
      tests++;
      if (start_cyc - last_wr_cyc != 1) begin
        fails++;
        $display("FAIL %s_start_timing: start %0d cycles after last write, required 1", nm, start_cyc - last_wr_cyc);
      end
    end
    // Clear and start together in DONE: clear wins, no new run.
    @(negedge clk);
    cfg_clear = 1'b1;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    cfg_start = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || sif.s_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s_clear_wins: done=%b busy=%b ready=%b, required 0 0 0", nm, done, busy, sif.s_ready);
    end
  endtask

  task automatic test_reset();
    logic [179:0] outs;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    outs = {sif.s_ready, bram_addr_a, bram_wdata_a, bram_we_a, bram_addr_b, bram_wdata_b,
            bram_we_b, mm_start_reg, mm_clear_done_reg, busy, done, err};
    tests++;
    if (outs !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full();
    run_op("full", 10'h000, 8'd8, 8, 8'hFF, 10'h100, 8'd16, 8, 8'hFF, 7, 7, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_op("gaps", 10'h000, 8'd8, 8, 8'hFF, 10'h100, 8'd16, 8, 8'hFF, 7, 7, 1'b1, 1'b0);
  endtask

  task automatic test_partial();
    run_op("partial", 10'h040, 8'd8, 3, 8'h07, 10'h200, 8'd8, 0, 8'hFF, 2, -1, 1'b0, 1'b0);
  endtask

  task automatic test_early_last();
    run_op("early_last", 10'h000, 8'd8, 4, 8'hFF, 10'h100, 8'd16, 8, 8'hF0, 1, 7, 1'b0, 1'b1);
  endtask

  task automatic test_missing_last();
    run_op("missing_last", 10'h010, 8'd24, 2, 8'h3C, 10'h300, 8'd8, 2, 8'hFF, -1, 1, 1'b1, 1'b1);
  endtask

  task automatic test_wrap();
    run_op("wrap", 10'h3F8, 8'd8, 2, 8'hFF, 10'h000, 8'd8, 0, 8'hFF, 1, -1, 1'b0, 1'b0);
    tests++;
    if (bram_addr_a !== 10'h000) begin
      fails++;
      $display("FAIL wrap_addr: last A addr=%h, required 000", bram_addr_a);
    end
  endtask

  task automatic test_reset_mid();
    logic [179:0] outs;
    @(negedge clk);
    cfg_addr_a = 10'h000; cfg_stride_a = 8'd8;  cfg_rows_a = 4'd8; cfg_mask_a = 8'hFF;
    cfg_addr_b = 10'h100; cfg_stride_b = 8'd16; cfg_rows_b = 4'd8; cfg_mask_b = 8'hFF;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int r = 0; r < 8; r++) send_row(1'b0, r, r == 7, 1'b0, 10'h000, 8'd8, 8'hFF);
    for (int r = 0; r < 2; r++) send_row(1'b1, r, 1'b0, 1'b0, 10'h100, 8'd16, 8'hFF);
    // Row 2 of B is offered in the same cycle reset hits; it must be dropped.
    @(negedge clk);
    sif.s_valid = 1'b1;
    sif.s_data  = 64'hDEAD_BEEF_0123_4567;
    sif.s_last  = 1'b0;
    tests++;
    if (sif.s_ready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pre: ready=%b busy=%b, required 1 1", sif.s_ready, busy);
    end
    resetn = 1'b0;
    @(posedge clk);
    #1;
    outs = {sif.s_ready, bram_addr_a, bram_wdata_a, bram_we_a, bram_addr_b, bram_wdata_b,
            bram_we_b, mm_start_reg, mm_clear_done_reg, busy, done, err};
    tests++;
    if (outs !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %h, required 0", outs);
    end
    @(negedge clk);
    sif.s_valid = 1'b0;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (start_cnt != 0 + 6) begin
      fails++;
      $display("FAIL reset_mid_no_start: start pulses=%0d, required 6", start_cnt);
    end
    run_op("after_reset", 10'h000, 8'd8, 8, 8'hFF, 10'h100, 8'd16, 8, 8'hFF, 7, 7, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full();
    test_backpressure();
    test_partial();
    test_early_last();
    test_missing_last();
    test_wrap();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mat_input_loader.md
Name: mat_input_loader

Overview:
- Upstream feeder for the 8x8 matmul-with-RAM top.
- Accepts matrix A then matrix B as a valid/ready stream of 64-bit rows and writes them into the A and B RAMs at configured base/stride.
- Then pulses start_reg, waits for the multiplier's done, pulses clear_done_reg and reports completion.
- Runs on the matmul clock; the RAM write ports are clocked by the same clk in this configuration.

Parameters:
DWIDTH, 8, bits per matrix element
MAT_MUL_SIZE, 8, elements per row and rows per matrix
AWIDTH, 10, RAM byte-address width
ADDR_STRIDE_WIDTH, 8, row stride width (bytes)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
cfg_start  in  1  start pulse; sampled only in IDLE
cfg_clear  in  1  acknowledge done; DONE->IDLE
cfg_addr_a  in  AWIDTH  A base byte address
cfg_addr_b  in  AWIDTH  B base byte address
cfg_stride_a  in  ADDR_STRIDE_WIDTH  A row stride
cfg_stride_b  in  ADDR_STRIDE_WIDTH  B row stride
cfg_rows_a  in  4  A rows to load, 0..8
cfg_rows_b  in  4  B rows to load, 0..8
cfg_mask_a  in  8  byte enables applied to every A row
cfg_mask_b  in  8  byte enables applied to every B row
s_valid  in  1  stream row valid
s_data  in  64  row; byte k = element k
s_last  in  1  final row of current matrix
s_ready  out  1  loader accepts row
bram_addr_a  out  AWIDTH  A RAM address
bram_wdata_a  out  64  A RAM write data
bram_we_a  out  8  A RAM byte write enables
bram_addr_b  out  AWIDTH  B RAM address
bram_wdata_b  out  64  B RAM write data
bram_we_b  out  8  B RAM byte write enables
mm_start_reg  out  1  to matmul start_reg
mm_clear_done_reg  out  1  to matmul clear_done_reg
mm_done  in  1  matmul done_mat_mul
busy  out  1  high in any state but IDLE/DONE
done  out  1  high in DONE
err  out  1  sticky framing error; cleared on accepted cfg_start

Behaviour:
- Reset: state IDLE; all outputs 0 (addresses, wdata, we, s_ready, mm_*, busy, done, err); row counter 0.
- Config latched on accepted cfg_start. Config changes after start are ignored.
- States: IDLE, LOAD_A, LOAD_B, START, WAIT, CLEAR, DONE.
- IDLE: on cfg_start, latch config, clear err, go to LOAD_A. If cfg_rows_a==0, skip LOAD_A (and LOAD_B if cfg_rows_b==0).
- s_ready = 1 exactly in LOAD_A/LOAD_B (registered, from next-state).
- Write timing: a beat is accepted when s_valid && s_ready.
  - Next cycle: bram_we_x = cfg_mask_x, bram_wdata_x = s_data, bram_addr_x = base + row*stride (mod 2^AWIDTH).
  - bram_we_x is 0 in every cycle without a prior-cycle accept.
  - Address is a running accumulator: starts at base, adds stride per accepted row. No multiplier.
- Leaving a LOAD state: after cfg_rows beats accepted, or on early s_last.
  - Early s_last (row < rows-1): row written, remaining rows skipped, err=1.
  - Missing s_last on final row: err=1, proceed normally.
  - Row counter resets to 0 on each LOAD entry.
- Sequence: LOAD_A -> LOAD_B -> START.
  - START: mm_start_reg=1 for exactly one cycle, after the last B write has issued.
  - WAIT: hold until mm_done=1, then go to CLEAR.
  - CLEAR: mm_clear_done_reg=1 for one cycle -> DONE.
- DONE: done=1 until cfg_clear -> IDLE. cfg_start while busy or in DONE is ignored.
- Simultaneous cfg_clear and cfg_start in DONE: clear wins; start is not captured.
- Reset mid-operation: immediate return to IDLE with reset values.
  - Any pending write is dropped.
  - mm_start_reg is not reissued; the matmul top is reset by the same resetn.

Decomposition:
- Shared package: state encoding, MAT_MUL_SIZE/DWIDTH/AWIDTH/ADDR_STRIDE_WIDTH constants, row-count width.
- One sub-module, mat_row_writer: beat accept, running address, registered addr/wdata/we for one RAM. Instantiated twice (A, B) and enabled by the FSM.

Test Plan:
- Full load, rows_a=rows_b=8, addr_a=0, stride_a=8, addr_b=0x100, stride_b=16, masks 0xFF, s_valid always 1, s_last on row 7:
  - 8 A writes to 0x000..0x038 then 8 B writes to 0x100..0x170.
  - One mm_start_reg pulse; mm_done after 40 cycles -> one mm_clear_done_reg pulse, then done=1, err=0.
- Backpressure/gaps: s_valid random 50%, same config -> identical write contents/addresses; bram_we only in the cycle after each accept.
- Partial: rows_a=3, mask_a=0x07, rows_b=0 -> 3 A writes with we_a=0x07, no B writes, START right after the 3rd write.
- Early s_last on A row 1 of rows_a=4 -> 2 A writes, err=1, next beat goes to B; err clears on next cfg_start.
- Address wrap: addr_a=0x3F8, stride_a=8, rows_a=2 -> writes at 0x3F8 then 0x000.
- Reset during LOAD_B row 2 -> next cycle all outputs 0, state IDLE; subsequent cfg_start runs the full load cleanly.
